// File: rtl/music_pkg.sv
// Shared definitions for the melody sequencer: note codes, ROM entry packing,
// the 25-entry melody and default tick timing.
package music_pkg;

    localparam logic [2:0] NOTE_GS = 3'd0;
    localparam logic [2:0] NOTE_FS = 3'd1;
    localparam logic [2:0] NOTE_DS = 3'd2;
    localparam logic [2:0] NOTE_D  = 3'd3;
    localparam logic [2:0] NOTE_CS = 3'd4;
    localparam logic [2:0] NOTE_B  = 3'd5;

    localparam logic LEN_SHORT = 1'b0;
    localparam logic LEN_LONG  = 1'b1;

    localparam int DEF_TICK_CYCLES = 705372;
    localparam int DEF_SHORT_TICKS = 3;
    localparam int DEF_LONG_TICKS  = 7;
    localparam int DEF_SPACE_TICKS = 1;

    localparam int         MELODY_LEN = 25;
    localparam logic [4:0] LAST_POS   = 5'd24;

    // ROM entry packing: {note[2:0], length}
    typedef logic [3:0] rom_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NOTE  = 2'd1,
        ST_SPACE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam rom_entry_t MELODY [MELODY_LEN] = '{
        {NOTE_FS, LEN_LONG},  {NOTE_GS, LEN_LONG},  {NOTE_D,  LEN_SHORT}, {NOTE_DS, LEN_LONG},
        {NOTE_B,  LEN_SHORT}, {NOTE_D,  LEN_SHORT}, {NOTE_CS, LEN_SHORT}, {NOTE_B,  LEN_LONG},
        {NOTE_B,  LEN_LONG},  {NOTE_CS, LEN_LONG},  {NOTE_D,  LEN_LONG},  {NOTE_D,  LEN_SHORT},
        {NOTE_CS, LEN_SHORT}, {NOTE_B,  LEN_SHORT}, {NOTE_CS, LEN_SHORT}, {NOTE_DS, LEN_SHORT},
        {NOTE_FS, LEN_SHORT}, {NOTE_GS, LEN_SHORT}, {NOTE_DS, LEN_SHORT}, {NOTE_FS, LEN_SHORT},
        {NOTE_CS, LEN_SHORT}, {NOTE_D,  LEN_SHORT}, {NOTE_B,  LEN_SHORT}, {NOTE_CS, LEN_SHORT},
        {NOTE_B,  LEN_SHORT}
    };

    function automatic logic [2:0] entry_note(input rom_entry_t e);
        return e[3:1];
    endfunction

    function automatic logic entry_is_long(input rom_entry_t e);
        return e[0] == LEN_LONG;
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Sequencer-to-oscillator bundle. enable is a level (run/pause), not a
// handshake; note/gate/note_start/melody_pos/done are registered by the master.
interface melody_sequencer_if;
    import music_pkg::*;

    logic       enable;
    logic [2:0] note;
    logic       gate;
    logic       note_start;
    logic [4:0] melody_pos;
    logic       done;
    seq_state_t state_dbg;

    modport master (
        input  enable,
        output note, gate, note_start, melody_pos, done, state_dbg
    );

    modport slave (
        output enable,
        input  note, gate, note_start, melody_pos, done, state_dbg
    );

endinterface

// File: rtl/melody_sequencer_tick_divider.sv
// Free-running tick divider: counts 0..TICK_CYCLES-1 while run is high and
// emits a one-cycle tick on the wrap; clear restarts the count.
module tick_divider #(
    parameter int TICK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [19:0] LAST = 20'(TICK_CYCLES - 1);

    logic [19:0] cnt_q;

    assign tick = run && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + 20'd1;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps the melody ROM, driving registered note/gate timing.
// Define MELODY_LOOP_EN to replay forever instead of stopping in DONE.
module melody_sequencer
    import music_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int SHORT_TICKS = DEF_SHORT_TICKS,
    parameter int LONG_TICKS  = DEF_LONG_TICKS,
    parameter int SPACE_TICKS = DEF_SPACE_TICKS
) (
    input logic               clk,
    input logic               rst,
    melody_sequencer_if.master bus
);

    localparam logic [7:0] SHORT_LAST = 8'(SHORT_TICKS - 1);
    localparam logic [7:0] LONG_LAST  = 8'(LONG_TICKS - 1);
    localparam logic [7:0] SPACE_LAST = 8'(SPACE_TICKS - 1);

    seq_state_t state_q, state_d;
    logic [4:0] pos_q, pos_d;
    logic [7:0] ticks_q, ticks_d;
    logic       clear, run, tick;
    logic       start_d, gate_d, done_d;
    logic [2:0] note_d;
    logic [7:0] note_last;

    logic [2:0] note_q;
    logic       gate_q, start_q, done_q;

    tick_divider #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .run   (run),
        .tick  (tick)
    );

    // Counters only advance in an active phase with enable high.
    assign run       = bus.enable && (state_q == ST_NOTE || state_q == ST_SPACE);
    assign note_last = entry_is_long(MELODY[pos_q]) ? LONG_LAST : SHORT_LAST;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        ticks_d = ticks_q;
        clear   = 1'b0;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_NOTE;
                    pos_d   = 5'd0;
                    ticks_d = '0;
                    clear   = 1'b1;
                    start_d = 1'b1;
                end
            end
            ST_NOTE: begin
                if (tick) begin
                    if (ticks_q == note_last) begin
                        state_d = ST_SPACE;
                        ticks_d = '0;
                        clear   = 1'b1;
                    end else begin
                        ticks_d = ticks_q + 8'd1;
                    end
                end
            end
            ST_SPACE: begin
                if (tick) begin
                    if (ticks_q == SPACE_LAST) begin
                        ticks_d = '0;
                        clear   = 1'b1;
                        if (pos_q == LAST_POS) begin
`ifdef MELODY_LOOP_EN
                            state_d = ST_NOTE;
                            pos_d   = 5'd0;
                            start_d = 1'b1;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            state_d = ST_NOTE;
                            pos_d   = pos_q + 5'd1;
                            start_d = 1'b1;
                        end
                    end else begin
                        ticks_d = ticks_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase

        gate_d = (state_d == ST_NOTE) && bus.enable;
        note_d = (state_d == ST_IDLE) ? 3'd0 : entry_note(MELODY[pos_d]);
`ifdef MELODY_LOOP_EN
        done_d = 1'b0;
`else
        done_d = (state_d == ST_DONE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            ticks_q <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ticks_q <= ticks_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign bus.note       = note_q;
    assign bus.gate       = gate_q;
    assign bus.note_start = start_q;
    assign bus.melody_pos = pos_q;
    assign bus.done       = done_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_CYCLES=4 (short=12, long=28,
// space=4 cycles); covers both MELODY_LOOP_EN builds.
module tb_melody_sequencer;
  import music_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  melody_sequencer_if bus();

  melody_sequencer #(
    .TICK_CYCLES(4),
    .SHORT_TICKS(3),
    .LONG_TICKS(7),
    .SPACE_TICKS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Counts consecutive samples (including the current one) with gate == level;
  // leaves the bench on the first sample with the other level. -1 on timeout.
  task automatic measure(input logic level, output int n);
    bit hit;
    hit = 1'b0;
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      if (!hit) begin
        step();
        if (bus.gate !== level) hit = 1'b1;
        else n++;
      end
    end
    if (!hit) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    #1;
    checks++; if (bus.gate !== 1'b0) begin failures++; $display("FAIL reset_gate: got %0b expected 0", bus.gate); end
    checks++; if (bus.note !== 3'd0) begin failures++; $display("FAIL reset_note: got %0d expected 0", bus.note); end
    checks++; if (bus.note_start !== 1'b0) begin failures++; $display("FAIL reset_note_start: got %0b expected 0", bus.note_start); end
    checks++; if (bus.melody_pos !== 5'd0) begin failures++; $display("FAIL reset_pos: got %0d expected 0", bus.melody_pos); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    checks++; if (bus.state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", bus.state_dbg, ST_IDLE); end
    step();
    rst = 1'b0;
    step();
    step();
    checks++; if (bus.gate !== 1'b0 || bus.state_dbg !== ST_IDLE) begin failures++; $display("FAIL idle_hold: gate=%0b state=%0d expected gate=0 state=%0d", bus.gate, bus.state_dbg, ST_IDLE); end
  endtask

  task automatic test_first_entry();
    int n;
    apply_reset();
    bus.enable = 1'b1;
    step();
    checks++; if (bus.gate !== 1'b1) begin failures++; $display("FAIL start_gate: got %0b expected 1", bus.gate); end
    checks++; if (bus.note_start !== 1'b1) begin failures++; $display("FAIL start_pulse: got %0b expected 1", bus.note_start); end
    checks++; if (bus.note !== 3'd1) begin failures++; $display("FAIL start_note: got %0d expected 1", bus.note); end
    checks++; if (bus.melody_pos !== 5'd0) begin failures++; $display("FAIL start_pos: got %0d expected 0", bus.melody_pos); end
    step();
    checks++; if (bus.note_start !== 1'b0) begin failures++; $display("FAIL start_pulse_width: got %0b expected 0", bus.note_start); end
    measure(1'b1, n);
    checks++; if (n + 1 !== 28) begin failures++; $display("FAIL entry0_high: got %0d expected 28", n + 1); end
    measure(1'b0, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL entry0_space: got %0d expected 4", n); end
    checks++; if (bus.note !== 3'd0 || bus.melody_pos !== 5'd1 || bus.note_start !== 1'b1) begin failures++; $display("FAIL entry1_start: note=%0d pos=%0d ns=%0b expected note=0 pos=1 ns=1", bus.note, bus.melody_pos, bus.note_start); end
  endtask

  // Continues from the first sample of entry 1.
  task automatic test_short_entry();
    int n;
    measure(1'b1, n);
    checks++; if (n !== 28) begin failures++; $display("FAIL entry1_high: got %0d expected 28", n); end
    measure(1'b0, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL entry1_space: got %0d expected 4", n); end
    checks++; if (bus.note !== 3'd3 || bus.melody_pos !== 5'd2 || bus.note_start !== 1'b1) begin failures++; $display("FAIL entry2_start: note=%0d pos=%0d ns=%0b expected note=3 pos=2 ns=1", bus.note, bus.melody_pos, bus.note_start); end
    measure(1'b1, n);
    checks++; if (n !== 12) begin failures++; $display("FAIL entry2_high: got %0d expected 12", n); end
    measure(1'b0, n);
    checks++; if (bus.note !== 3'd2 || bus.melody_pos !== 5'd3) begin failures++; $display("FAIL entry3_start: note=%0d pos=%0d expected note=2 pos=3", bus.note, bus.melody_pos); end
  endtask

  task automatic test_pause();
    int high;
    int starts;
    int pause_high;
    bit fell;
    apply_reset();
    bus.enable = 1'b1;
    step();
    high = int'(bus.gate);
    starts = int'(bus.note_start);
    for (int i = 0; i < 10; i++) begin
      step();
      high += int'(bus.gate);
      starts += int'(bus.note_start);
    end
    bus.enable = 1'b0;
    pause_high = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pause_high += int'(bus.gate);
      starts += int'(bus.note_start);
    end
    checks++; if (pause_high !== 0) begin failures++; $display("FAIL pause_gate: got %0d high cycles expected 0", pause_high); end
    checks++; if (bus.note !== 3'd1 || bus.melody_pos !== 5'd0 || bus.state_dbg !== ST_NOTE) begin failures++; $display("FAIL pause_hold: note=%0d pos=%0d state=%0d expected note=1 pos=0 state=%0d", bus.note, bus.melody_pos, bus.state_dbg, ST_NOTE); end
    bus.enable = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!fell) begin
        step();
        if (bus.gate !== 1'b1) fell = 1'b1;
        else high++;
        starts += int'(bus.note_start);
      end
    end
    checks++; if (!fell) begin failures++; $display("FAIL pause_timeout: gate still high after 200 cycles, expected fall"); end
    checks++; if (high !== 28) begin failures++; $display("FAIL pause_total_high: got %0d expected 28", high); end
    checks++; if (starts !== 1) begin failures++; $display("FAIL pause_note_start: got %0d pulses expected 1", starts); end
  endtask

  task automatic test_reset_mid_space();
    bit found;
    apply_reset();
    bus.enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!found) begin
        step();
        if (bus.melody_pos == 5'd5 && bus.gate == 1'b0) found = 1'b1;
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL midspace_reach: pos=%0d gate=%0b expected pos=5 gate=0", bus.melody_pos, bus.gate); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (bus.gate !== 1'b0 || bus.note !== 3'd0 || bus.note_start !== 1'b0 || bus.melody_pos !== 5'd0 || bus.done !== 1'b0 || bus.state_dbg !== ST_IDLE) begin failures++; $display("FAIL async_reset: gate=%0b note=%0d ns=%0b pos=%0d done=%0b state=%0d expected all 0", bus.gate, bus.note, bus.note_start, bus.melody_pos, bus.done, bus.state_dbg); end
    step();
    rst = 1'b0;
    step();
    checks++; if (bus.gate !== 1'b1 || bus.note_start !== 1'b1 || bus.melody_pos !== 5'd0 || bus.note !== 3'd1) begin failures++; $display("FAIL restart: gate=%0b ns=%0b pos=%0d note=%0d expected 1 1 0 1", bus.gate, bus.note_start, bus.melody_pos, bus.note); end
  endtask

  task automatic test_full_run();
    int starts;
    int high;
    int done_early;
    bit ended;
    logic [4:0] prev_pos;
    apply_reset();
    bus.enable = 1'b1;
    starts = 0;
    high = 0;
    done_early = 0;
    ended = 1'b0;
    prev_pos = 5'd0;
    for (int i = 0; i < 2000; i++) begin
      if (!ended) begin
        step();
`ifdef MELODY_LOOP_EN
        if (bus.melody_pos == 5'd0 && prev_pos == 5'd24) ended = 1'b1;
        done_early += int'(bus.done);
`else
        if (bus.done == 1'b1) ended = 1'b1;
`endif
        if (!ended) begin
          starts += int'(bus.note_start);
          high += int'(bus.gate);
        end
        prev_pos = bus.melody_pos;
      end
    end
    checks++; if (!ended) begin failures++; $display("FAIL full_timeout: melody did not finish in 2000 cycles, pos=%0d", bus.melody_pos); end
    checks++; if (starts !== 25) begin failures++; $display("FAIL full_starts: got %0d expected 25", starts); end
    checks++; if (high !== 412) begin failures++; $display("FAIL full_high: got %0d expected 412", high); end
`ifdef MELODY_LOOP_EN
    checks++; if (done_early !== 0) begin failures++; $display("FAIL loop_done: done high %0d cycles expected 0", done_early); end
    checks++; if (bus.note_start !== 1'b1 || bus.gate !== 1'b1 || bus.note !== 3'd1) begin failures++; $display("FAIL loop_wrap: ns=%0b gate=%0b note=%0d expected 1 1 1", bus.note_start, bus.gate, bus.note); end
`else
    checks++; if (bus.gate !== 1'b0 || bus.melody_pos !== 5'd24 || bus.state_dbg !== ST_DONE) begin failures++; $display("FAIL done_state: gate=%0b pos=%0d state=%0d expected 0 24 %0d", bus.gate, bus.melody_pos, bus.state_dbg, ST_DONE); end
    high = 0;
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      high += int'(bus.gate) + int'(bus.note_start);
    end
    checks++; if (high !== 0 || bus.done !== 1'b1 || bus.melody_pos !== 5'd24) begin failures++; $display("FAIL done_sticky: activity=%0d done=%0b pos=%0d expected 0 1 24", high, bus.done, bus.melody_pos); end
`endif
  endtask

  initial begin
    bus.enable = 1'b0;
    test_reset();
    test_first_entry();
    test_short_entry();
    test_pause();
    test_reset_mid_space();
    test_full_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
